// File: rtl/uart_frame_tx_sequencer.sv
// Frame sequencer for a single uart_tx byte transmitter: 4-byte magic header,
// latched payload, CRC-16/CCITT-FALSE trailer, per-byte handshake and stall timeout.
module uart_frame_tx_sequencer #(
  parameter int          PAYLOAD_BYTES  = 16,
  parameter logic [31:0] MAGICNUMBER    = 32'hDABBAD00,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  input  logic                       abort,
  output logic                       busy,
  output logic                       tx_enable,
  output logic                       frame_done,
  output logic                       timeout_err,
  output logic                       tx_transmit,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [2:0]                 dbg_state
);

  localparam int TOTAL = PAYLOAD_BYTES + 6;
  localparam int IDX_W = $clog2(TOTAL);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] PAY_FIRST = IDX_W'(4);
  localparam logic [IDX_W-1:0] PAY_END   = IDX_W'(PAYLOAD_BYTES + 4);
  // The counter is cleared in FIRE, one cycle after tx_transmit rises, so the
  // limit sits two below TIMEOUT_CYCLES to make timeout_err land exactly
  // TIMEOUT_CYCLES cycles after the transmit pulse.
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FIRE = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [15:0]                crc;
  logic [TMO_W-1:0]           tmo_cnt;
  logic [8*PAYLOAD_BYTES-1:0] pl_q;

  logic [8*TOTAL-1:0]         frame_vec;
  logic [7:0]                 cur_byte;
  logic                       in_payload;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int b = 0; b < 8; b++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // Byte k of the frame lives at frame_vec[8k +: 8]; header goes out MSB first.
  assign frame_vec = {crc[7:0], crc[15:8], pl_q,
                      MAGICNUMBER[7:0], MAGICNUMBER[15:8],
                      MAGICNUMBER[23:16], MAGICNUMBER[31:24]};
  assign cur_byte   = frame_vec[{idx, 3'b000} +: 8];
  assign in_payload = (idx >= PAY_FIRST) && (idx < PAY_END);
  assign dbg_state  = state;

  // uart_tx handshake: tx_byte is loaded only while tx_active=0, tx_transmit is
  // a single-cycle strobe with tx_byte already valid, and tx_byte then holds
  // until the matching one-cycle tx_done (or abort/timeout) ends the byte.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      crc         <= 16'hFFFF;
      tmo_cnt     <= '0;
      pl_q        <= '0;
      busy        <= 1'b0;
      tx_enable   <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      tx_transmit <= 1'b0;
      tx_byte     <= 8'h00;
    end else begin
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      tx_transmit <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        tx_enable <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (frame_start) begin
              pl_q      <= payload;
              crc       <= 16'hFFFF;
              idx       <= '0;
              busy      <= 1'b1;
              tx_enable <= 1'b1;
              state     <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (!tx_active) begin
              tx_byte     <= cur_byte;
              tx_transmit <= 1'b1;
              if (in_payload) crc <= crc16_byte(crc, cur_byte);
              state       <= S_FIRE;
            end
          end
          S_FIRE: begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
          S_WAIT: begin
            if (tx_done) begin
              if (idx == LAST_IDX) begin
                frame_done <= 1'b1;
                state      <= S_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_LOAD;
              end
            end else if (tmo_cnt == TMO_LIMIT) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              tx_enable   <= 1'b0;
              state       <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_DONE: begin
            busy      <= 1'b0;
            tx_enable <= 1'b0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx_sequencer.sv
// Bench for uart_frame_tx_sequencer: behavioural uart_tx models, a frame
// reference model (header + payload + bit-serial CRC) and one task per scenario.
module tb_uart_frame_tx_sequencer;

  localparam int P   = 9;
  localparam int TMO = 200;
  localparam logic [31:0] MAGIC = 32'hDABBAD00;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  // ---------------- DUT A (9-byte payload, short timeout) ----------------
  logic           frame_start, abort, busy, tx_enable, frame_done, timeout_err, tx_transmit;
  logic [8*P-1:0] payload;
  logic [7:0]     tx_byte;
  logic           tx_active, tx_done;
  logic [2:0]     dbg_state;

  uart_frame_tx_sequencer #(.PAYLOAD_BYTES(P), .MAGICNUMBER(MAGIC), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .rst_n(rst_n), .frame_start(frame_start), .payload(payload), .abort(abort),
    .busy(busy), .tx_enable(tx_enable), .frame_done(frame_done), .timeout_err(timeout_err),
    .tx_transmit(tx_transmit), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT B (default parameters) ----------------
  logic         frame_start_b, abort_b, busy_b, tx_enable_b, frame_done_b, timeout_err_b, tx_transmit_b;
  logic [127:0] payload_b;
  logic [7:0]   tx_byte_b;
  logic         tx_active_b, tx_done_b;
  logic [2:0]   dbg_state_b;

  uart_frame_tx_sequencer dut_b (
    .CLK(CLK), .rst_n(rst_n), .frame_start(frame_start_b), .payload(payload_b), .abort(abort_b),
    .busy(busy_b), .tx_enable(tx_enable_b), .frame_done(frame_done_b), .timeout_err(timeout_err_b),
    .tx_transmit(tx_transmit_b), .tx_byte(tx_byte_b), .tx_active(tx_active_b), .tx_done(tx_done_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- uart_tx behavioural models ----------------
  int   ack_delay = 20;
  int   stall_idx = -1;
  logic hold_active = 1'b0;
  logic inj_done = 1'b0;
  int   m_cnt, m_n;
  logic m_act, m_done, m_stall;

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_done <= 1'b0; m_stall <= 1'b0; m_cnt <= 0; m_n <= 0;
    end else begin
      m_done <= 1'b0;
      if (tx_transmit) begin
        m_act   <= 1'b1;
        m_cnt   <= ack_delay;
        m_n     <= m_n + 1;
        m_stall <= (m_n == stall_idx);
      end else if (m_act && !m_stall) begin
        if (m_cnt <= 1) begin m_done <= 1'b1; m_act <= 1'b0; end
        else m_cnt <= m_cnt - 1;
      end
    end
  end
  assign tx_active = m_act | hold_active;
  assign tx_done   = m_done | inj_done;

  int   mb_cnt;
  logic mb_act, mb_done;
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mb_act <= 1'b0; mb_done <= 1'b0; mb_cnt <= 0;
    end else begin
      mb_done <= 1'b0;
      if (tx_transmit_b) begin mb_act <= 1'b1; mb_cnt <= 5; end
      else if (mb_act) begin
        if (mb_cnt <= 1) begin mb_done <= 1'b1; mb_act <= 1'b0; end
        else mb_cnt <= mb_cnt - 1;
      end
    end
  end
  assign tx_active_b = mb_act;
  assign tx_done_b   = mb_done;

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         tx_cyc_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         fd_seen, te_seen;
  int         fd_cyc, te_cyc, last_done, en_bad;

  function automatic logic [15:0] crc_ccitt(input logic [7:0] d[$]);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    foreach (d[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[15] ^ d[i][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  function automatic void build_exp(input logic [7:0] d[$]);
    logic [15:0] c;
    logic [31:0] m;
    m = MAGIC;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(m[31-8*i -: 8]);
    foreach (d[i]) exp_q.push_back(d[i]);
    c = crc_ccitt(d);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
  endfunction

  function automatic void exp_from_pl(input logic [8*P-1:0] pl);
    logic [7:0] d[$];
    for (int k = 0; k < P; k++) d.push_back(pl[8*k +: 8]);
    build_exp(d);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    hold_active = 1'b0; inj_done = 1'b0; stall_idx = -1; abort = 1'b0; frame_start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic start_frame(input logic [8*P-1:0] pl);
    @(negedge CLK);
    payload = pl;
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
  endtask

  // Samples DUT A once per cycle until frame_done, timeout_err or the budget runs out.
  task automatic collect_frame(input int max_cyc);
    got_q.delete(); tx_cyc_q.delete();
    fd_seen = 0; te_seen = 0; fd_cyc = -1; te_cyc = -1; last_done = -100; en_bad = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (tx_transmit) begin got_q.push_back(tx_byte); tx_cyc_q.push_back(c); end
      if (tx_done) last_done = c;
      if (busy && !tx_enable) en_bad++;
      if (frame_done) begin fd_seen = 1; fd_cyc = c; end
      if (timeout_err) begin te_seen = 1; te_cyc = c; end
      if (fd_seen || te_seen) break;
      @(negedge CLK);
    end
  endtask

  task automatic wait_transmits(input int n, output bit ok);
    int seen = 0;
    for (int c = 0; c < 3000 && seen < n; c++) begin
      @(negedge CLK);
      if (tx_transmit) seen++;
    end
    ok = (seen == n);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (tx_enable !== 1'b0) begin n_err++; $display("FAIL reset_tx_enable: got %b want 0", tx_enable); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_vec++; if (tx_transmit !== 1'b0) begin n_err++; $display("FAIL reset_tx_transmit: got %b want 0", tx_transmit); end
    n_vec++; if (tx_byte !== 8'h00) begin n_err++; $display("FAIL reset_tx_byte: got %02h want 00", tx_byte); end
    n_vec++; if (busy_b !== 1'b0 || tx_byte_b !== 8'h00) begin n_err++; $display("FAIL reset_dut_b: got busy=%b byte=%02h want 0/00", busy_b, tx_byte_b); end
    rst_n = 1'b1;
    repeat (3) @(negedge CLK);
    n_vec++; if (busy !== 1'b0 || tx_transmit !== 1'b0) begin n_err++; $display("FAIL reset_idle: got busy=%b tx=%b want 0/0", busy, tx_transmit); end
  endtask

  task automatic check_frame(input string tag);
    n_vec++; if (fd_seen !== 1'b1) begin n_err++; $display("FAIL %s_frame_done: got %b want 1", tag, fd_seen); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL %s_pulse_count: got %0d want %0d", tag, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL %s_byte%0d: got %02h want %02h", tag, i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_cyc - last_done != 1) begin n_err++; $display("FAIL %s_done_latency: got %0d want 1", tag, fd_cyc - last_done); end
    n_vec++; if (en_bad != 0) begin n_err++; $display("FAIL %s_tx_enable_drop: got %0d want 0", tag, en_bad); end
    @(negedge CLK);
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL %s_done_width: got %b want 0", tag, frame_done); end
    @(negedge CLK);
    n_vec++; if (busy !== 1'b0 || tx_enable !== 1'b0) begin n_err++; $display("FAIL %s_end_idle: got busy=%b en=%b want 0/0", tag, busy, tx_enable); end
  endtask

  task automatic test_known_vector();
    logic [8*P-1:0] pl;
    apply_reset();
    ack_delay = 20;
    pl = 72'h393837363534333231;
    exp_from_pl(pl);
    start_frame(pl);
    n_vec++; if (busy !== 1'b1 || tx_enable !== 1'b1) begin n_err++; $display("FAIL kv_accept: got busy=%b en=%b want 1/1", busy, tx_enable); end
    collect_frame(2000);
    n_vec++; if (got_q.size() != 15) begin n_err++; $display("FAIL kv_count15: got %0d want 15", got_q.size()); end
    if (got_q.size() == 15) begin
      n_vec++; if ({got_q[13], got_q[14]} !== 16'h29B1) begin n_err++; $display("FAIL kv_crc: got %02h%02h want 29b1", got_q[13], got_q[14]); end
    end
    check_frame("kv");
  endtask

  task automatic test_random_frames();
    logic [8*P-1:0] pl;
    apply_reset();
    for (int it = 0; it < 4; it++) begin
      pl = (8*P)'({$urandom(), $urandom(), $urandom()});
      ack_delay = $urandom_range(1, 25);
      exp_from_pl(pl);
      start_frame(pl);
      collect_frame(2000);
      check_frame("rand");
    end
  endtask

  task automatic test_zero_payload();
    logic [7:0] d[$];
    bit fd = 0;
    apply_reset();
    for (int k = 0; k < 16; k++) d.push_back(8'h00);
    build_exp(d);
    got_q.delete();
    payload_b = '0;
    @(negedge CLK); frame_start_b = 1'b1;
    @(negedge CLK); frame_start_b = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (tx_transmit_b) got_q.push_back(tx_byte_b);
      if (frame_done_b) begin fd = 1; break; end
      @(negedge CLK);
    end
    n_vec++; if (fd !== 1'b1) begin n_err++; $display("FAIL zero_frame_done: got %b want 1", fd); end
    n_vec++; if (got_q.size() != 22) begin n_err++; $display("FAIL zero_count22: got %0d want 22", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL zero_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    repeat (2) @(negedge CLK);
    n_vec++; if (busy_b !== 1'b0 || tx_enable_b !== 1'b0) begin n_err++; $display("FAIL zero_end_idle: got busy=%b en=%b want 0/0", busy_b, tx_enable_b); end
  endtask

  task automatic test_timeout();
    logic [8*P-1:0] pl;
    int gap, extra;
    apply_reset();
    ack_delay = 10;
    stall_idx = 5;
    pl = (8*P)'({$urandom(), $urandom(), $urandom()});
    start_frame(pl);
    collect_frame(3000);
    gap = (tx_cyc_q.size() > 5) ? te_cyc - tx_cyc_q[5] : -1;
    n_vec++; if (te_seen !== 1'b1) begin n_err++; $display("FAIL tmo_seen: got %b want 1", te_seen); end
    n_vec++; if (gap != TMO) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", gap, TMO); end
    n_vec++; if (got_q.size() != 6) begin n_err++; $display("FAIL tmo_pulses: got %0d want 6", got_q.size()); end
    n_vec++; if (fd_seen !== 1'b0) begin n_err++; $display("FAIL tmo_no_done: got %b want 0", fd_seen); end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (frame_done || timeout_err || tx_transmit) extra++;
    end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL tmo_quiet_after: got %0d want 0", extra); end
    n_vec++; if (busy !== 1'b0 || tx_enable !== 1'b0) begin n_err++; $display("FAIL tmo_idle: got busy=%b en=%b want 0/0", busy, tx_enable); end
    stall_idx = -1;
  endtask

  task automatic test_abort();
    logic [8*P-1:0] pl;
    bit ok;
    int n_tx, n_fd, n_te;
    apply_reset();
    ack_delay = 20;
    pl = (8*P)'({$urandom(), $urandom(), $urandom()});
    start_frame(pl);
    wait_transmits(11, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL abort_reach_byte10: got %b want 1", ok); end
    repeat (3) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    n_vec++; if (busy !== 1'b0 || tx_enable !== 1'b0) begin n_err++; $display("FAIL abort_idle: got busy=%b en=%b want 0/0", busy, tx_enable); end
    abort = 1'b0;
    n_tx = 0; n_fd = 0; n_te = 0;
    for (int c = 0; c < TMO + 50; c++) begin
      @(negedge CLK);
      if (tx_transmit) n_tx++;
      if (frame_done) n_fd++;
      if (timeout_err) n_te++;
    end
    n_vec++; if (n_tx != 0) begin n_err++; $display("FAIL abort_no_tx: got %0d want 0", n_tx); end
    n_vec++; if (n_fd != 0 || n_te != 0) begin n_err++; $display("FAIL abort_no_pulse: got done=%0d tmo=%0d want 0/0", n_fd, n_te); end
    pl = (8*P)'({$urandom(), $urandom(), $urandom()});
    exp_from_pl(pl);
    start_frame(pl);
    collect_frame(2000);
    if (got_q.size() > 0) begin
      n_vec++; if (got_q[0] !== 8'hDA) begin n_err++; $display("FAIL abort_restart_hdr: got %02h want da", got_q[0]); end
    end
    check_frame("restart");
  endtask

  task automatic test_async_reset();
    logic [8*P-1:0] pl;
    bit ok;
    int n_tx, n_busy;
    apply_reset();
    ack_delay = 15;
    pl = (8*P)'({$urandom(), $urandom(), $urandom()});
    start_frame(pl);
    wait_transmits(6, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL arst_reach_payload: got %b want 1", ok); end
    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || tx_enable !== 1'b0) begin n_err++; $display("FAIL arst_busy_en: got busy=%b en=%b want 0/0", busy, tx_enable); end
    n_vec++; if (tx_byte !== 8'h00 || tx_transmit !== 1'b0) begin n_err++; $display("FAIL arst_byte: got byte=%02h tx=%b want 00/0", tx_byte, tx_transmit); end
    n_vec++; if (frame_done !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL arst_pulses: got done=%b tmo=%b want 0/0", frame_done, timeout_err); end
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK); inj_done = 1'b1;
    @(negedge CLK); inj_done = 1'b0;
    n_tx = 0; n_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (tx_transmit) n_tx++;
      if (busy) n_busy++;
    end
    n_vec++; if (n_tx != 0 || n_busy != 0) begin n_err++; $display("FAIL arst_ignore_done: got tx=%0d busy=%0d want 0/0", n_tx, n_busy); end
  endtask

  task automatic test_busy_ignore();
    logic [8*P-1:0] pl;
    int n_tx, first, n_busy;
    bit fd;
    apply_reset();
    ack_delay = 8;
    pl = (8*P)'({$urandom(), $urandom(), $urandom()});
    exp_from_pl(pl);
    hold_active = 1'b1;
    start_frame(pl);
    n_tx = 0;
    repeat (50) begin
      @(negedge CLK);
      if (tx_transmit) n_tx++;
    end
    n_vec++; if (n_tx != 0) begin n_err++; $display("FAIL hold_no_tx: got %0d want 0", n_tx); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy: got %b want 1", busy); end
    hold_active = 1'b0;
    got_q.delete(); first = -1; fd = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      frame_start = 1'b0;
      if (tx_transmit) begin
        if (first < 0) first = c;
        got_q.push_back(tx_byte);
        if (got_q.size() == 7) begin frame_start = 1'b1; payload = ~pl; end
      end
      if (frame_done) begin fd = 1; break; end
    end
    frame_start = 1'b0;
    n_vec++; if (first != 0) begin n_err++; $display("FAIL hold_release_latency: got %0d want 0", first); end
    n_vec++; if (fd !== 1'b1) begin n_err++; $display("FAIL busy_frame_done: got %b want 1", fd); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL busy_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL busy_byte%0d: got %02h want %02h", i, got_q[i], exp_q[i]); end
    end
    n_tx = 0; n_busy = 0;
    repeat (2) @(negedge CLK);
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (tx_transmit) n_tx++;
      if (busy) n_busy++;
    end
    n_vec++; if (n_tx != 0 || n_busy != 0) begin n_err++; $display("FAIL busy_second_ignored: got tx=%0d busy=%0d want 0/0", n_tx, n_busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    frame_start = 1'b0; abort = 1'b0; payload = '0;
    frame_start_b = 1'b0; abort_b = 1'b0; payload_b = '0;
    rst_n = 1'b0;
    test_reset();
    test_known_vector();
    test_random_frames();
    test_zero_payload();
    test_timeout();
    test_abort();
    test_async_reset();
    test_busy_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
